// File: rtl/mastermind_scorer_pkg.sv
// Shared types, width helpers and peg-slicing for the Mastermind scoring engine.
package mastermind_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLACK = 2'd1,
    WHITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int MAX_VEC_W   = 256;
  localparam int MAX_COLOR_W = 16;

  function automatic int cnt_width(input int num_pegs);
    return $clog2(num_pegs + 1);
  endfunction

  function automatic int try_width(input int max_tries);
    return $clog2(max_tries + 1);
  endfunction

  // Colour of peg idx in a packed code; callers zero-extend their code to MAX_VEC_W.
  function automatic logic [MAX_COLOR_W-1:0] peg_color(input logic [MAX_VEC_W-1:0] vec,
                                                       input int idx, input int cbits);
    logic [MAX_COLOR_W-1:0] mask;
    mask = MAX_COLOR_W'((32'd1 << cbits) - 32'd1);
    return MAX_COLOR_W'(vec >> (idx * cbits)) & mask;
  endfunction

endpackage

// File: rtl/mastermind_scorer_if.sv
// Secret/guess/score bundle between the input logic (master) and the scorer (slave).
interface mastermind_scorer_if
  import mastermind_pkg::*;
#(
  parameter int NUM_PEGS   = 4,
  parameter int COLOR_BITS = 3,
  parameter int MAX_TRIES  = 10
) ();
  localparam int VEC_W = NUM_PEGS * COLOR_BITS;
  localparam int CNT_W = cnt_width(NUM_PEGS);
  localparam int TRY_W = try_width(MAX_TRIES);

  logic                  secret_load;
  logic [VEC_W-1:0]      secret_in;
  logic                  guess_valid;
  logic [VEC_W-1:0]      guess_in;
  logic                  guess_ready;
  logic                  score_valid;
  logic [CNT_W-1:0]      black_count;
  logic [CNT_W-1:0]      white_count;
  logic [TRY_W-1:0]      attempts;
  logic                  win;
  logic                  lose;
  logic [2*NUM_PEGS-1:0] peg_led;

  modport master (
    output secret_load, secret_in, guess_valid, guess_in,
    input  guess_ready, score_valid, black_count, white_count, attempts, win, lose, peg_led
  );

  modport slave (
    input  secret_load, secret_in, guess_valid, guess_in,
    output guess_ready, score_valid, black_count, white_count, attempts, win, lose, peg_led
  );
endinterface

// File: rtl/mastermind_scorer_peg_thermometer.sv
// Count-to-thermometer converter driving one half of the peg LED bar.
module peg_thermometer #(
  parameter int NUM_PEGS = 4,
  parameter int CNT_W    = 3
) (
  input  logic [CNT_W-1:0]    count,
  output logic [NUM_PEGS-1:0] therm
);
  // LED k lights when more than k pegs are counted.
  always_comb begin
    therm = '0;
    for (int k = 0; k < NUM_PEGS; k++) begin
      therm[k] = (count > CNT_W'(k));
    end
  end
endmodule

// File: rtl/mastermind_scorer.sv
// Sequential Mastermind scorer: exact matches in one cycle, then one guess peg per cycle
// for colour-only matches, with attempt tracking and sticky win/lose.
module mastermind_scorer
  import mastermind_pkg::*;
#(
  parameter int NUM_PEGS   = 4,
  parameter int COLOR_BITS = 3,
  parameter int MAX_TRIES  = 10
) (
  input logic          MAX10_CLK1_50,
  input logic          rst,
  mastermind_scorer_if.slave bus
);
  localparam int VEC_W = NUM_PEGS * COLOR_BITS;
  localparam int CNT_W = cnt_width(NUM_PEGS);
  localparam int TRY_W = try_width(MAX_TRIES);

  state_t                 state_r;
  logic [VEC_W-1:0]       secret_r, guess_r;
  logic [NUM_PEGS-1:0]    gused_r, sused_r;
  logic [CNT_W-1:0]       black_r, white_r, idx_r;
  logic [CNT_W-1:0]       black_count_r, white_count_r;
  logic [TRY_W-1:0]       attempts_r;
  logic                   win_r, lose_r, score_valid_r;

  logic [NUM_PEGS-1:0]    match_s, take_mask_s, black_therm_s, white_therm_s;
  logic [CNT_W-1:0]       black_s, white_next_s;
  logic [TRY_W-1:0]       attempts_next_s;
  logic [MAX_COLOR_W-1:0] gi_s;
  logic                   skip_s, guess_ready_s;

  function automatic logic [MAX_COLOR_W-1:0] color_at(input logic [VEC_W-1:0] v, input int k);
    return peg_color(MAX_VEC_W'(v), k, COLOR_BITS);
  endfunction

  assign guess_ready_s = (state_r == IDLE) && !win_r && !lose_r;

  // Exact-position match mask and its population count.
  always_comb begin
    match_s = '0;
    black_s = '0;
    for (int k = 0; k < NUM_PEGS; k++) begin
      match_s[k] = (color_at(guess_r, k) == color_at(secret_r, k));
      black_s    = black_s + CNT_W'(match_s[k]);
    end
  end

  // One white step: lowest unused secret peg matching the current guess peg.
  always_comb begin
    gi_s        = '0;
    skip_s      = 1'b0;
    take_mask_s = '0;
    for (int k = 0; k < NUM_PEGS; k++) begin
      gi_s   = (idx_r == CNT_W'(k)) ? color_at(guess_r, k) : gi_s;
      skip_s = (idx_r == CNT_W'(k)) ? gused_r[k] : skip_s;
    end
    for (int j = NUM_PEGS - 1; j >= 0; j--) begin
      if (!skip_s && !sused_r[j] && (color_at(secret_r, j) == gi_s)) begin
        take_mask_s    = '0;
        take_mask_s[j] = 1'b1;
      end else begin
        take_mask_s = take_mask_s;
      end
    end
    white_next_s    = white_r + CNT_W'(|take_mask_s);
    attempts_next_s = (attempts_r == TRY_W'(MAX_TRIES)) ? attempts_r : attempts_r + TRY_W'(1);
  end

  // Scoring FSM and all registered outputs.
  always_ff @(posedge MAX10_CLK1_50) begin
    if (rst) begin
      state_r       <= IDLE;
      secret_r      <= '0;
      guess_r       <= '0;
      gused_r       <= '0;
      sused_r       <= '0;
      black_r       <= '0;
      white_r       <= '0;
      idx_r         <= '0;
      black_count_r <= '0;
      white_count_r <= '0;
      attempts_r    <= '0;
      win_r         <= 1'b0;
      lose_r        <= 1'b0;
      score_valid_r <= 1'b0;
    end else begin
      score_valid_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (bus.secret_load) begin
            secret_r      <= bus.secret_in;
            attempts_r    <= '0;
            win_r         <= 1'b0;
            lose_r        <= 1'b0;
            black_count_r <= '0;
            white_count_r <= '0;
          end else if (bus.guess_valid && guess_ready_s) begin
            guess_r <= bus.guess_in;
            state_r <= BLACK;
          end
        end
        BLACK: begin
          gused_r <= match_s;
          sused_r <= match_s;
          black_r <= black_s;
          white_r <= '0;
          idx_r   <= '0;
          state_r <= WHITE;
        end
        WHITE: begin
          sused_r <= sused_r | take_mask_s;
          white_r <= white_next_s;
          idx_r   <= idx_r + CNT_W'(1);
          // Results are registered on the last step so they are valid throughout DONE.
          if (idx_r == CNT_W'(NUM_PEGS - 1)) begin
            state_r       <= DONE;
            score_valid_r <= 1'b1;
            black_count_r <= black_r;
            white_count_r <= white_next_s;
            attempts_r    <= attempts_next_s;
            if (black_r == CNT_W'(NUM_PEGS)) begin
              win_r <= 1'b1;
            end else if (attempts_next_s == TRY_W'(MAX_TRIES)) begin
              lose_r <= 1'b1;
            end
          end
        end
        DONE: begin
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  peg_thermometer #(.NUM_PEGS(NUM_PEGS), .CNT_W(CNT_W)) u_black_therm (
    .count (black_count_r),
    .therm (black_therm_s)
  );

  peg_thermometer #(.NUM_PEGS(NUM_PEGS), .CNT_W(CNT_W)) u_white_therm (
    .count (white_count_r),
    .therm (white_therm_s)
  );

  assign bus.guess_ready = guess_ready_s;
  assign bus.score_valid = score_valid_r;
  assign bus.black_count = black_count_r;
  assign bus.white_count = white_count_r;
  assign bus.attempts    = attempts_r;
  assign bus.win         = win_r;
  assign bus.lose        = lose_r;
  assign bus.peg_led     = {white_therm_s, black_therm_s};
endmodule
